// File: rtl/addsub_pkg.sv
// Shared encodings for the add/subtract accumulator: command opcodes, FSM states,
// slice width and the signed-overflow rule used on the most significant slice.
package addsub_pkg;

    localparam int SLICE = 4;

    typedef enum logic [1:0] {
        OP_LOAD = 2'b00,
        OP_ADD  = 2'b01,
        OP_SUB  = 2'b10,
        OP_CLR  = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        HOLD = 2'b10
    } state_t;

    // Two's-complement overflow: operands agree in sign but the sum does not.
    function automatic logic signed_ovf(input logic a_msb, input logic b_msb,
                                        input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

endpackage

// File: rtl/addsub_slice4.sv
// Combinational 4-bit add/subtract slice; the b operand is inverted when sub is set,
// so subtraction is completed by feeding cin=1 into the least significant slice.
module addsub_slice4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       sub,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    logic [3:0] w_b_eff;
    logic [4:0] w_total;

    assign w_b_eff = b ^ {4{sub}};
    assign w_total = {1'b0, a} + {1'b0, w_b_eff} + {4'b0000, cin};
    assign sum     = w_total[3:0];
    assign cout    = w_total[4];

endmodule

// File: rtl/addsub_accumulator.sv
// Accumulator that applies LOAD/ADD/SUB/CLR commands, evaluating ADD/SUB one 4-bit
// slice per cycle (LSB first) with a registered carry, and holds the result until taken.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are both high;
// valid, once raised, holds its payload stable until that edge; ready may change freely.
module addsub_accumulator
    import addsub_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             res_carry,
    output logic             res_ovf,
    output logic             res_zero,
    output logic             busy,
    output state_t           dbg_state
);

    localparam int N     = WIDTH / SLICE;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]   r_b;
    logic               r_sub;
    logic               r_c;
    logic [WIDTH-1:0]   r_res_data;
    logic               r_res_carry;
    logic               r_res_ovf;
    logic               r_res_zero;
    logic               r_res_valid;

    logic [SLICE-1:0]   w_a_slice;
    logic [SLICE-1:0]   w_b_slice;
    logic [SLICE-1:0]   w_sum;
    logic               w_cout;
    logic [WIDTH-1:0]   w_acc_next;
    logic               w_last;
    logic               w_ovf;
    logic               w_take;

    assign w_a_slice = r_acc[{r_cnt, 2'b00} +: SLICE];
    assign w_b_slice = r_b[{r_cnt, 2'b00} +: SLICE];
    assign w_last    = (r_cnt == CNT_W'(N - 1));
    assign w_take    = r_res_valid && res_ready;

    addsub_slice4 u_slice (
        .a    (w_a_slice),
        .b    (w_b_slice),
        .sub  (r_sub),
        .cin  (r_c),
        .sum  (w_sum),
        .cout (w_cout)
    );

    always_comb begin
        w_acc_next = r_acc;
        w_acc_next[{r_cnt, 2'b00} +: SLICE] = w_sum;
    end

    // Only meaningful on the last slice, where w_a_slice/w_b_slice hold the MSBs.
    assign w_ovf = signed_ovf(r_acc[WIDTH-1], r_b[WIDTH-1] ^ r_sub, w_sum[SLICE-1]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_acc       <= '0;
            r_b         <= '0;
            r_sub       <= 1'b0;
            r_c         <= 1'b0;
            r_res_data  <= '0;
            r_res_carry <= 1'b0;
            r_res_ovf   <= 1'b0;
            r_res_zero  <= 1'b0;
            r_res_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (cmd_valid) begin
                        case (op_t'(cmd_op))
                            OP_LOAD: begin
                                r_acc       <= cmd_data;
                                r_res_data  <= cmd_data;
                                r_res_carry <= 1'b0;
                                r_res_ovf   <= 1'b0;
                                r_res_zero  <= (cmd_data == '0);
                                r_res_valid <= 1'b1;
                                r_state     <= HOLD;
                            end
                            OP_CLR: begin
                                r_acc       <= '0;
                                r_res_data  <= '0;
                                r_res_carry <= 1'b0;
                                r_res_ovf   <= 1'b0;
                                r_res_zero  <= 1'b1;
                                r_res_valid <= 1'b1;
                                r_state     <= HOLD;
                            end
                            default: begin
                                r_b     <= cmd_data;
                                r_sub   <= (op_t'(cmd_op) == OP_SUB);
                                r_c     <= (op_t'(cmd_op) == OP_SUB);
                                r_cnt   <= '0;
                                r_state <= CALC;
                            end
                        endcase
                    end
                end
                CALC: begin
                    r_acc <= w_acc_next;
                    r_c   <= w_cout;
                    if (w_last) begin
                        r_res_data  <= w_acc_next;
                        r_res_carry <= w_cout;
                        r_res_ovf   <= w_ovf;
                        r_res_zero  <= (w_acc_next == '0);
                        r_res_valid <= 1'b1;
                        r_state     <= HOLD;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                HOLD: begin
                    if (w_take) begin
                        r_res_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Gated by rst_n so every output reads 0 while reset is asserted.
    assign cmd_ready = rst_n && (r_state == IDLE);
    assign busy      = (r_state != IDLE);
    assign res_valid = r_res_valid;
    assign res_data  = r_res_data;
    assign res_carry = r_res_carry;
    assign res_ovf   = r_res_ovf;
    assign res_zero  = r_res_zero;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_addsub_accumulator.sv
// Directed bench for addsub_accumulator (WIDTH=16) with hand-computed expectations.
module tb_addsub_accumulator;
    import addsub_pkg::*;

    localparam int W = 16;

    logic         clk;
    logic         rst_n;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [1:0]   cmd_op;
    logic [W-1:0] cmd_data;
    logic         res_valid;
    logic         res_ready;
    logic [W-1:0] res_data;
    logic         res_carry;
    logic         res_ovf;
    logic         res_zero;
    logic         busy;
    state_t       dbg_state;

    int checks = 0;
    int errors = 0;
    int lat;

    addsub_accumulator #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_carry (res_carry),
        .res_ovf   (res_ovf),
        .res_zero  (res_zero),
        .busy      (busy),
        .dbg_state (dbg_state)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Checking
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_result(input string tag, input logic [W-1:0] d, input logic c,
                              input logic o, input logic z);
        chk({tag, ".valid"}, 32'(res_valid), 32'(1'b1));
        chk({tag, ".data"},  32'(res_data),  32'(d));
        chk({tag, ".carry"}, 32'(res_carry), 32'(c));
        chk({tag, ".ovf"},   32'(res_ovf),   32'(o));
        chk({tag, ".zero"},  32'(res_zero),  32'(z));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".cmd_ready"}, 32'(cmd_ready), 32'(1'b0));
        chk({tag, ".res_valid"}, 32'(res_valid), 32'(1'b0));
        chk({tag, ".res_data"},  32'(res_data),  32'(0));
        chk({tag, ".flags"},     32'({res_carry, res_ovf, res_zero}), 32'(0));
        chk({tag, ".busy"},      32'(busy),      32'(1'b0));
    endtask

    // Drivers: inputs change 1 time unit after the rising edge
    task automatic accept_cmd(input op_t op, input logic [W-1:0] data);
        int n;
        cmd_op    = op;
        cmd_data  = data;
        cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("accept.cmd_ready", 32'(cmd_ready), 32'(1'b1));
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cmd_data  = W'($urandom_range(0, 65535));
        cmd_op    = 2'($urandom_range(0, 3));
    endtask

    // lat counts cycles after the accept cycle; 1 means visible right after the accept edge.
    task automatic wait_result(output int l);
        l = 1;
        while (!res_valid && l < 30) begin
            @(posedge clk); #1;
            l++;
        end
    endtask

    task automatic take_result();
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        chk("take.res_valid", 32'(res_valid), 32'(1'b0));
        chk("take.cmd_ready", 32'(cmd_ready), 32'(1'b1));
    endtask

    task automatic run_cmd(input string tag, input op_t op, input logic [W-1:0] data,
                           input int exp_lat, input logic [W-1:0] d, input logic c,
                           input logic o, input logic z);
        accept_cmd(op, data);
        wait_result(lat);
        chk({tag, ".latency"}, 32'(lat), 32'(exp_lat));
        chk_result(tag, d, c, o, z);
        take_result();
    endtask

    // Directed sequence
    initial begin
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_data  = '0;
        res_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_reset.cmd_ready", 32'(cmd_ready), 32'(1'b1));
        chk("post_reset.busy", 32'(busy), 32'(1'b0));
        chk("post_reset.state", 32'(dbg_state), 32'(IDLE));

        run_cmd("load_1234", OP_LOAD, 16'h1234, 1, 16'h1234, 1'b0, 1'b0, 1'b0);

        // Watch the datapath mid-calculation: busy, CALC state, command blocked.
        accept_cmd(OP_ADD, 16'h0FFF);
        chk("add.busy", 32'(busy), 32'(1'b1));
        chk("add.state", 32'(dbg_state), 32'(CALC));
        chk("add.cmd_ready", 32'(cmd_ready), 32'(1'b0));
        wait_result(lat);
        chk("add_0fff.latency", 32'(lat), 32'(5));
        chk_result("add_0fff", 16'h2233, 1'b0, 1'b0, 1'b0);
        take_result();

        run_cmd("load_ffff", OP_LOAD, 16'hFFFF, 1, 16'hFFFF, 1'b0, 1'b0, 1'b0);
        run_cmd("add_wrap",  OP_ADD,  16'h0001, 5, 16'h0000, 1'b1, 1'b0, 1'b1);

        run_cmd("load_3",    OP_LOAD, 16'h0003, 1, 16'h0003, 1'b0, 1'b0, 1'b0);
        run_cmd("sub_borrow", OP_SUB, 16'h0005, 5, 16'hFFFE, 1'b0, 1'b0, 1'b0);
        run_cmd("load_5",    OP_LOAD, 16'h0005, 1, 16'h0005, 1'b0, 1'b0, 1'b0);
        run_cmd("sub_equal", OP_SUB,  16'h0005, 5, 16'h0000, 1'b1, 1'b0, 1'b1);

        run_cmd("load_7fff", OP_LOAD, 16'h7FFF, 1, 16'h7FFF, 1'b0, 1'b0, 1'b0);
        run_cmd("add_ovf",   OP_ADD,  16'h0001, 5, 16'h8000, 1'b0, 1'b1, 1'b0);
        run_cmd("load_8000", OP_LOAD, 16'h8000, 1, 16'h8000, 1'b0, 1'b0, 1'b0);
        run_cmd("sub_ovf",   OP_SUB,  16'h0001, 5, 16'h7FFF, 1'b1, 1'b1, 1'b0);

        // Accumulate onto the previous result: 0x7FFF + 0x1001 = 0x9000, signed overflow.
        run_cmd("add_chain", OP_ADD,  16'h1001, 5, 16'h9000, 1'b0, 1'b1, 1'b0);
        // 0x9000 - 0xA000 borrows and stays in range: 0xF000.
        run_cmd("sub_chain", OP_SUB,  16'hA000, 5, 16'hF000, 1'b0, 1'b0, 1'b0);

        // Back-pressure in HOLD: result stays put and new commands are refused.
        accept_cmd(OP_LOAD, 16'hABCD);
        wait_result(lat);
        chk("stall.latency", 32'(lat), 32'(1));
        for (int i = 0; i < 10; i++) begin
            cmd_valid = i[0];
            cmd_op    = OP_CLR;
            @(posedge clk); #1;
            chk("stall.cmd_ready", 32'(cmd_ready), 32'(1'b0));
            chk("stall.state", 32'(dbg_state), 32'(HOLD));
            chk_result("stall", 16'hABCD, 1'b0, 1'b0, 1'b0);
        end
        cmd_valid = 1'b0;
        take_result();
        run_cmd("clr", OP_CLR, 16'h5A5A, 1, 16'h0000, 1'b0, 1'b0, 1'b1);

        // Async reset in the middle of slice 2 throws away the partial sum.
        run_cmd("load_0010", OP_LOAD, 16'h0010, 1, 16'h0010, 1'b0, 1'b0, 1'b0);
        accept_cmd(OP_ADD, 16'h1111);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("mid_calc.state", 32'(dbg_state), 32'(CALC));
        #2 rst_n = 1'b0;
        #1;
        chk_all_zero("mid_reset");
        @(posedge clk); #1;
        chk_all_zero("mid_reset_held");
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("mid_release.cmd_ready", 32'(cmd_ready), 32'(1'b1));
        run_cmd("add_after_reset", OP_ADD, 16'h0001, 5, 16'h0001, 1'b0, 1'b0, 1'b0);

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
